// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: req/gnt + rvalid data bus with lane steering and load extension.
// Optional build macro MISALIGN_TRAP_EN traps misaligned H/W accesses instead of issuing them.
module lsu_bus_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ld_q, ld_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;

    logic              legal_in;
    logic              mis_in;
    logic [CNT_W-1:0]  cnt_inc;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       ext;
    logic [3:0]        be;
    logic [31:0]       wd_lanes;

    always_comb begin
        legal_in = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
        mis_in = (funct3[1:0] == 2'b01 && addr[0])
              || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
        mis_in = 1'b0;
`endif
    end

    // Load extraction works on the registered address and width.
    always_comb begin
        rbyte = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        rhalf = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (f3_q)
            3'b000:  ext = {{24{rbyte[7]}}, rbyte};
            3'b100:  ext = {24'd0, rbyte};
            3'b001:  ext = {{16{rhalf[15]}}, rhalf};
            3'b101:  ext = {16'd0, rhalf};
            default: ext = bus_rdata;
        endcase
    end

    always_comb begin
        unique case (f3_q[1:0])
            2'b00: begin
                be       = 4'b0001 << addr_q[1:0];
                wd_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << {addr_q[1], 1'b0};
                wd_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wd_lanes = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        err_d   = err_q;
        mis_d   = mis_q;
        cnt_inc = cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (!legal_in || mis_in) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        mis_d   = legal_in & mis_in;
                        ld_d    = 32'd0;
                    end else begin
                        state_d = REQ;
                        err_d   = 1'b0;
                        mis_d   = 1'b0;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_d = we_q ? DONE : WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (bus_rvalid) begin
                    state_d = DONE;
                    ld_d    = ext;
                end else if (cnt_inc == TMO) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    ld_d    = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= '0;
            ld_q    <= 32'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // Reset gates stall directly so the pipeline is released in the reset cycle.
    assign stall     = req_valid & ~reset & (state_q != DONE);
    assign done      = (state_q == DONE);
    assign err       = done & err_q;
    assign misalign  = done & mis_q;
    assign load_data = ld_q;
    assign bus_req   = (state_q == REQ);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? be : 4'd0;
    assign bus_wdata = (bus_req & we_q) ? wd_lanes : 32'd0;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed vector table, reset/timeout sequences,
// and random accesses checked against a byte-level reference model.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, err, misalign;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_bus_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .load_data(load_data),
        .err(err), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        bit          bus;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        bit          err;
        bit          mis;
        int          lat;
    } exp_t;

    typedef struct {
        bit          bus_seen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        int          lat;
        logic        err;
        logic        mis;
        logic [31:0] ld;
        bit          stall_bad;
    } obs_t;

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gdly;
        int          rdly;
        bit          bus;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] ld;
        bit          err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input bit we, input logic [2:0] f3,
                                   input logic [31:0] a, wd, rd,
                                   input int gdly, rdly);
        exp_t        e;
        int          size, off, bem;
        bit          legal;
        logic [31:0] v;
        e = '{default: 0};
        legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        size = 1 << f3[1:0];
`ifdef MISALIGN_TRAP_EN
        e.mis = legal && (a % size) != 0;
`endif
        if (!legal || e.mis) begin
            e.err = 1;
            e.lat = 1;
            return e;
        end
        e.bus = 1;
        e.addr = a - a % 4;
        off = (a % 4) / size * size;
        bem = ((1 << size) - 1) << off;
        e.be = bem[3:0];
        for (int i = 0; i < 4; i++)
            e.wd[8*i +: 8] = wd[8*(i % size) +: 8];
        if (we) begin
            e.lat = gdly + 2;
        end else if (rdly < 0 || rdly >= 255) begin
            e.err = 1;
            e.ld = 0;
            e.lat = gdly + 257;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++)
                v[8*i +: 8] = rd[8*(off + i) +: 8];
            if (!f3[2] && size < 4 && v[8*size-1])
                for (int i = size; i < 4; i++)
                    v[8*i +: 8] = 8'hFF;
            e.ld = v;
            e.lat = gdly + rdly + 3;
        end
        return e;
    endfunction

    // Entered at a negedge; leaves req_valid high at the next negedge
    // after done so a following call forms a back-to-back access.
    task automatic run_access(input bit we, input logic [2:0] f3,
                              input logic [31:0] a, wd, rd,
                              input int gdly, rdly, input bit noise,
                              output obs_t o);
        int nreq, gcyc;
        bit granted;
        o = '{default: 0};
        o.lat = -1;
        nreq = 0;
        gcyc = 0;
        granted = 0;
        req_valid = 1;
        req_we = we;
        funct3 = f3;
        addr = a;
        wdata = wd;
        bus_rdata = rd;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            bus_gnt = 0;
            bus_rvalid = 0;
            if (done) begin
                o.lat = cyc;
                o.err = err;
                o.mis = misalign;
                o.ld = load_data;
                if (stall) o.stall_bad = 1;
                break;
            end
            if (!stall) o.stall_bad = 1;
            if (bus_req) begin
                o.bus_seen = 1;
                if (nreq == gdly) begin
                    bus_gnt = 1;
                    granted = 1;
                    gcyc = cyc;
                    o.addr = bus_addr;
                    o.be = bus_be;
                    o.wd = bus_wdata;
                    o.we = bus_we;
                end else if (noise) begin
                    bus_rvalid = 1'($urandom_range(0, 1));
                end
                nreq++;
            end else if (granted) begin
                if (rdly >= 0 && cyc == gcyc + 1 + rdly)
                    bus_rvalid = 1;
                else if (noise)
                    bus_gnt = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        bus_gnt = 0;
        bus_rvalid = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic cmp(input string t, input bit we, input exp_t e,
                       input obs_t o);
        chk({t, ".lat"}, o.lat, e.lat);
        chk({t, ".err"}, o.err, e.err);
        chk({t, ".mis"}, o.mis, e.mis);
        chk({t, ".bus"}, o.bus_seen, e.bus);
        chk({t, ".stall"}, o.stall_bad, 0);
        if (e.bus && o.bus_seen) begin
            chk({t, ".addr"}, o.addr, e.addr);
            chk({t, ".we"}, o.we, we);
            if (we) begin
                chk({t, ".be"}, o.be, e.be);
                chk({t, ".wdata"}, o.wd, e.wd);
            end
        end
        if (!we && e.bus)
            chk({t, ".ld"}, o.ld, e.ld);
    endtask

    initial begin
        vec_t tbl[13];
        obs_t o;
        exp_t e;
        int   dn;

        tbl[0]  = '{1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 0,
                    1, 4'hF, 32'hDEADBEEF, 0, 0, 3};
        tbl[1]  = '{1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0,
                    1, 4'h8, 32'hA5A5A5A5, 0, 0, 2};
        tbl[2]  = '{0, 3'b000, 32'h102, 0, 32'h12F03456, 0, 0,
                    1, 0, 0, 32'hFFFFFFF0, 0, 3};
        tbl[3]  = '{0, 3'b100, 32'h102, 0, 32'h12F03456, 0, 0,
                    1, 0, 0, 32'h000000F0, 0, 3};
        tbl[4]  = '{0, 3'b001, 32'h102, 0, 32'h80010000, 0, 0,
                    1, 0, 0, 32'hFFFF8001, 0, 3};
        tbl[5]  = '{0, 3'b101, 32'h102, 0, 32'h80010000, 0, 0,
                    1, 0, 0, 32'h00008001, 0, 3};
        tbl[6]  = '{1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0,
                    1, 4'hC, 32'hABCDABCD, 0, 0, 2};
        tbl[7]  = '{0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 2, 3,
                    1, 0, 0, 32'hCAFEF00D, 0, 8};
        tbl[8]  = '{1, 3'b011, 32'h104, 32'h1, 0, 0, 0,
                    0, 0, 0, 0, 1, 1};
        tbl[9]  = '{0, 3'b110, 32'h104, 0, 0, 0, 0,
                    0, 0, 0, 0, 1, 1};
        tbl[10] = '{0, 3'b111, 32'h104, 0, 0, 0, 0,
                    0, 0, 0, 0, 1, 1};
        tbl[11] = '{0, 3'b000, 32'h101, 0, 32'h00007F00, 0, 0,
                    1, 0, 0, 32'h0000007F, 0, 3};
        tbl[12] = '{1, 3'b000, 32'h100, 32'h12345678, 0, 3, 0,
                    1, 4'h1, 32'h78787878, 0, 0, 5};

        reset = 1;
        req_valid = 0;
        req_we = 0;
        funct3 = 0;
        addr = 0;
        wdata = 0;
        bus_gnt = 0;
        bus_rvalid = 0;
        bus_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst.ctl", {stall, done, err, misalign, bus_req, bus_we, bus_be}, 0);
        chk("rst.ld", load_data, 0);
        chk("rst.baddr", bus_addr, 0);
        chk("rst.bwd", bus_wdata, 0);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                       tbl[i].rd, tbl[i].gdly, tbl[i].rdly, 0, o);
            e = '{default: 0};
            e.bus = tbl[i].bus;
            e.addr = tbl[i].addr & 32'hFFFF_FFFC;
            e.be = tbl[i].be;
            e.wd = tbl[i].exp_wd;
            e.ld = tbl[i].ld;
            e.err = tbl[i].err;
            e.lat = tbl[i].lat;
            cmp($sformatf("vec%0d", i), tbl[i].we, e, o);
            if (i % 3 == 0) idle(1);
        end
        idle(1);

        // Normal load followed by timeout: load_data must fall to zero.
        run_access(0, 3'b010, 32'h300, 0, 32'h55AA55AA, 0, 0, 0, o);
        chk("pre_tmo.ld", o.ld, 32'h55AA55AA);
        run_access(0, 3'b010, 32'h300, 0, 32'h55AA55AA, 0, -1, 0, o);
        chk("tmo.lat", o.lat, 257);
        chk("tmo.err", o.err, 1);
        chk("tmo.ld", o.ld, 0);
        idle(1);

        run_access(0, 3'b010, 32'h101, 0, 32'h11223344, 0, 0, 0, o);
`ifdef MISALIGN_TRAP_EN
        chk("mis.bus", o.bus_seen, 0);
        chk("mis.lat", o.lat, 1);
        chk("mis.err", o.err, 1);
        chk("mis.flag", o.mis, 1);
`else
        chk("mis.baddr", o.addr, 32'h100);
        chk("mis.ld", o.ld, 32'h11223344);
        chk("mis.err", o.err, 0);
        chk("mis.flag", o.mis, 0);
`endif
        idle(1);

        // Reset while requesting: bus_req falls without a clock edge.
        req_valid = 1;
        req_we = 1;
        funct3 = 3'b010;
        addr = 32'h500;
        wdata = 32'h1;
        @(negedge clk);
        #1;
        chk("rq.pre", bus_req, 1);
        reset = 1;
        #1;
        chk("rq.breq", bus_req, 0);
        chk("rq.stall", stall, 0);
        @(negedge clk);
        reset = 0;
        req_valid = 0;
        @(negedge clk);
        #1;
        chk("rq.post", bus_req, 0);
        @(negedge clk);

        // Reset in WAIT, then a stray rvalid must not complete anything.
        req_valid = 1;
        req_we = 0;
        funct3 = 3'b010;
        addr = 32'h600;
        @(negedge clk);
        #1;
        bus_gnt = 1;
        @(negedge clk);
        bus_gnt = 0;
        #1;
        chk("wt.pre", stall, 1);
        reset = 1;
        #1;
        chk("wt.stall", stall, 0);
        chk("wt.breq", bus_req, 0);
        @(negedge clk);
        reset = 0;
        req_valid = 0;
        repeat (2) @(negedge clk);
        bus_rdata = 32'h9999_9999;
        bus_rvalid = 1;
        dn = 0;
        repeat (5) begin
            #1;
            if (done) dn++;
            @(negedge clk);
            bus_rvalid = 0;
        end
        chk("wt.nodone", dn, 0);
        run_access(0, 3'b011, 32'h700, 0, 0, 0, 0, 0, o);
        chk("wt.ill.err", o.err, 1);
        chk("wt.ill.bus", o.bus_seen, 0);
        idle(1);

        for (int n = 0; n < 150; n++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] a, wd, rd;
            int          gdly, rdly, r;
            we = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 19);
            if (r >= 17)
                f3 = (r == 17) ? 3'b011 : (r == 18) ? 3'b110 : 3'b111;
            else if (we)
                f3 = 3'(r % 3);
            else
                f3 = (r % 5 < 3) ? 3'(r % 5) : 3'(r % 5 + 1);
            a = $urandom;
            wd = $urandom;
            rd = $urandom;
            gdly = $urandom_range(0, 3);
            rdly = ($urandom_range(0, 29) == 0) ? -1 : $urandom_range(0, 4);
            e = model(we, f3, a, wd, rd, gdly, rdly);
            run_access(we, f3, a, wd, rd, gdly, rdly,
                       1'($urandom_range(0, 1)), o);
            cmp($sformatf("rnd%0d", n), we, e, o);
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 2));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
